warp_wb_collector: RTL and testbench

Downstream stage of the SM compute box. Tracks one issued warp instruction at a time and captures per-lane results from the 32 shared CUDA cores as each core raises its done pulse; cores may finish in any order. Once every active lane has completed, or a timeout expires, it presents a single warp-wide register-file writeback with a valid/ready handshake. On acceptance it releases the warp's scoreboard entry.

---
 rtl/sm_pkg.sv | 17 +
 rtl/warp_wb_collector_if.sv | 38 +++
 rtl/wb_lane_buffer.sv | 32 +++
 rtl/warp_wb_collector.sv | 107 ++++++++++
 tb/tb_warp_wb_collector.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sm_pkg.sv
// Shared SM types: warp/register identifiers, lane masks and writeback collector states.
package sm_pkg;
  localparam int unsigned SM_NUM_THREADS = 32;
  localparam int unsigned SM_WARP_ID_W   = 5;
  localparam int unsigned SM_REG_ID_W    = 6;
  localparam int unsigned SM_TIMEOUT     = 255;

  typedef logic [SM_WARP_ID_W-1:0]   warp_id_t;
  typedef logic [SM_REG_ID_W-1:0]    reg_id_t;
  typedef logic [SM_NUM_THREADS-1:0] lane_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } wb_state_t;
endpackage

// File: rtl/warp_wb_collector_if.sv
// Issue, core completion, writeback and scoreboard-release signals of the warp writeback collector.
interface warp_wb_collector_if #(
  parameter int unsigned NUM_THREADS = 32,
  parameter int unsigned W           = 32,
  parameter int unsigned WARP_ID_W   = 5,
  parameter int unsigned REG_ID_W    = 6
);
  logic                            issue_valid;
  logic                            issue_ready;
  logic [WARP_ID_W-1:0]            issue_warp_id;
  logic [REG_ID_W-1:0]             issue_dst_reg;
  logic [NUM_THREADS-1:0]          issue_mask;
  logic [NUM_THREADS-1:0]          core_done;
  logic [NUM_THREADS-1:0][W-1:0]   core_result;
  logic                            wb_valid;
  logic                            wb_ready;
  logic [WARP_ID_W-1:0]            wb_warp_id;
  logic [REG_ID_W-1:0]             wb_dst_reg;
  logic [NUM_THREADS-1:0]          wb_mask;
  logic [NUM_THREADS-1:0][W-1:0]   wb_data;
  logic                            sb_release_valid;
  logic [WARP_ID_W-1:0]            sb_release_warp_id;
  logic                            err_timeout;

  modport master (
    output issue_valid, issue_warp_id, issue_dst_reg, issue_mask,
    output core_done, core_result, wb_ready,
    input  issue_ready, wb_valid, wb_warp_id, wb_dst_reg, wb_mask, wb_data,
    input  sb_release_valid, sb_release_warp_id, err_timeout
  );

  modport slave (
    input  issue_valid, issue_warp_id, issue_dst_reg, issue_mask,
    input  core_done, core_result, wb_ready,
    output issue_ready, wb_valid, wb_warp_id, wb_dst_reg, wb_mask, wb_data,
    output sb_release_valid, sb_release_warp_id, err_timeout
  );
endinterface

// File: rtl/wb_lane_buffer.sv
// Per-lane pending mask and result capture; only the first done on a pending lane is stored.
module wb_lane_buffer #(
  parameter int unsigned NUM_THREADS = 32,
  parameter int unsigned W           = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NUM_THREADS-1:0]        mask,
  input  logic [NUM_THREADS-1:0]        done,
  input  logic [NUM_THREADS-1:0][W-1:0] result,
  input  logic                          clear,
  output logic [NUM_THREADS-1:0]        pending,
  output logic [NUM_THREADS-1:0][W-1:0] buffer
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      buffer  <= '0;
    end else if (clear) begin
      pending <= '0;
      buffer  <= '0;
    end else if (load) begin
      pending <= mask;
    end else begin
      pending <= pending & ~done;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        if (done[i] && pending[i]) buffer[i] <= result[i];
      end
    end
  end
endmodule

// File: rtl/warp_wb_collector.sv
// Collects per-lane core results for one in-flight warp and issues a single register-file writeback.
module warp_wb_collector
  import sm_pkg::*;
#(
  parameter int unsigned NUM_THREADS = SM_NUM_THREADS,
  parameter int unsigned W           = 32,
  parameter int unsigned WARP_ID_W   = SM_WARP_ID_W,
  parameter int unsigned REG_ID_W    = SM_REG_ID_W,
  parameter int unsigned TIMEOUT     = SM_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  warp_wb_collector_if.slave bus
);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  wb_state_t                     state, state_nxt;
  logic [TW-1:0]                 timer;
  logic [WARP_ID_W-1:0]          warp_id;
  logic [REG_ID_W-1:0]           dst_reg;
  logic [NUM_THREADS-1:0]        lmask;
  logic [NUM_THREADS-1:0]        pending;
  logic [NUM_THREADS-1:0][W-1:0] buffer;
  logic [NUM_THREADS-1:0]        done_eff;
  logic                          load, clear, err;

  wb_lane_buffer #(.NUM_THREADS(NUM_THREADS), .W(W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .mask    (bus.issue_mask),
    .done    (done_eff),
    .result  (bus.core_result),
    .clear   (clear),
    .pending (pending),
    .buffer  (buffer)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion uses the post-capture pending set so the final done leaves COLLECT in the same cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clear     = 1'b0;
    err       = 1'b0;
    done_eff  = '0;
    case (state)
      IDLE: begin
        if (bus.issue_valid) begin
          load      = 1'b1;
          state_nxt = (|bus.issue_mask) ? COLLECT : WRITE;
        end
      end
      COLLECT: begin
        done_eff = bus.core_done;
        if ((pending & ~bus.core_done) == '0) begin
          state_nxt = WRITE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (bus.wb_ready) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      warp_id <= '0;
      dst_reg <= '0;
      lmask   <= '0;
    end else if (load) begin
      timer   <= '0;
      warp_id <= bus.issue_warp_id;
      dst_reg <= bus.issue_dst_reg;
      lmask   <= bus.issue_mask;
    end else if (state == COLLECT) begin
      timer <= timer + TW'(1);
    end
  end

  always_comb begin
    bus.issue_ready        = (state == IDLE);
    bus.wb_valid           = (state == WRITE);
    bus.wb_warp_id         = warp_id;
    bus.wb_dst_reg         = dst_reg;
    bus.wb_mask            = bus.wb_valid ? (lmask & ~pending) : '0;
    bus.sb_release_valid   = bus.wb_valid & bus.wb_ready;
    bus.sb_release_warp_id = warp_id;
    bus.err_timeout        = err;
    bus.wb_data            = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      if (bus.wb_mask[i]) bus.wb_data[i] = buffer[i];
    end
  end
endmodule

// File: tb/tb_warp_wb_collector.sv
// Randomized and directed checks of warp_wb_collector against a per-warp outcome model.
module tb_warp_wb_collector;
  localparam int unsigned N  = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  int          done_cyc [N];
  int          dup_cyc  [N];
  logic [31:0] res1     [N];
  logic [31:0] res2     [N];

  warp_wb_collector_if #(.NUM_THREADS(N), .W(32), .WARP_ID_W(5), .REG_ID_W(6)) bus ();

  warp_wb_collector #(
    .NUM_THREADS(N), .W(32), .WARP_ID_W(5), .REG_ID_W(6), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input logic [4:0] wid, input logic [5:0] dreg, input logic [31:0] emask);
    chk("wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("wb_warp_id", 64'(bus.wb_warp_id), 64'(wid));
    chk("wb_dst_reg", 64'(bus.wb_dst_reg), 64'(dreg));
    chk("wb_mask", 64'(bus.wb_mask), 64'(emask));
    chk("issue_ready_wr", 64'(bus.issue_ready), 64'd0);
    chk("err_wr", 64'(bus.err_timeout), 64'd0);
    for (int l = 0; l < N; l++)
      chk($sformatf("wb_data[%0d]", l), 64'(bus.wb_data[l]), emask[l] ? 64'(res1[l]) : 64'd0);
  endtask

  task automatic garbage_done();
    bus.core_done = $urandom;
    for (int l = 0; l < N; l++) bus.core_result[l] = $urandom;
  endtask

  // One warp through issue, collection, optional stall and handshake; the outcome is
  // derived from lane completion times alone.
  task automatic do_warp(input logic [4:0] wid, input logic [5:0] dreg,
                         input logic [31:0] mask, input int stall);
    int          fin, last;
    bit          all_in;
    logic [31:0] emask;
    last   = 0;
    all_in = 1;
    for (int l = 0; l < N; l++) begin
      if (mask[l]) begin
        if (done_cyc[l] >= 1 && done_cyc[l] <= TO) last = (done_cyc[l] > last) ? done_cyc[l] : last;
        else all_in = 0;
      end
    end
    if (mask == 0)   fin = 0;
    else if (all_in) fin = last;
    else             fin = TO;
    emask = '0;
    for (int l = 0; l < N; l++)
      if (mask[l] && done_cyc[l] >= 1 && done_cyc[l] <= fin) emask[l] = 1'b1;

    @(negedge clk);
    bus.issue_valid   = 1'b1;
    bus.issue_warp_id = wid;
    bus.issue_dst_reg = dreg;
    bus.issue_mask    = mask;
    #1 chk("issue_ready", 64'(bus.issue_ready), 64'd1);
    @(posedge clk);
    for (int c = 1; c <= fin; c++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      bus.core_done   = '0;
      for (int l = 0; l < N; l++) begin
        bus.core_result[l] = $urandom;
        if (done_cyc[l] == c) begin
          bus.core_done[l] = 1'b1;
          bus.core_result[l] = res1[l];
        end else if (done_cyc[l] != 0 && dup_cyc[l] == c) begin
          bus.core_done[l] = 1'b1;
          bus.core_result[l] = res2[l];
        end
      end
      #1;
      chk("wb_valid_collect", 64'(bus.wb_valid), 64'd0);
      chk("err_timeout", 64'(bus.err_timeout), 64'((!all_in && mask != 0 && c == TO) ? 1 : 0));
      chk("sb_rel_collect", 64'(bus.sb_release_valid), 64'd0);
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    garbage_done();
    #1 chk_wb(wid, dreg, emask);
    chk("sb_rel_stall0", 64'(bus.sb_release_valid), 64'd0);
    for (int s = 0; s < stall; s++) begin
      bus.issue_valid   = 1'b1;
      bus.issue_warp_id = wid ^ 5'h1f;
      @(negedge clk);
      garbage_done();
      #1 chk_wb(wid, dreg, emask);
      chk("sb_rel_stall", 64'(bus.sb_release_valid), 64'd0);
    end
    bus.issue_valid = 1'b0;
    bus.core_done   = '0;
    bus.wb_ready    = 1'b1;
    #1;
    chk("sb_release_valid", 64'(bus.sb_release_valid), 64'd1);
    chk("sb_release_warp_id", 64'(bus.sb_release_warp_id), 64'(wid));
    @(negedge clk);
    bus.wb_ready = 1'b0;
    #1;
    chk("issue_ready_after", 64'(bus.issue_ready), 64'd1);
    chk("sb_release_once", 64'(bus.sb_release_valid), 64'd0);
    chk("wb_valid_after", 64'(bus.wb_valid), 64'd0);
  endtask

  task automatic clear_sched();
    for (int l = 0; l < N; l++) begin
      done_cyc[l] = 0;
      dup_cyc[l]  = 0;
      res1[l]     = $urandom;
      res2[l]     = $urandom;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_mask", 64'(bus.wb_mask), 64'd0);
    chk("rst_wb_data", 64'(|bus.wb_data), 64'd0);
    chk("rst_wb_warp_id", 64'(bus.wb_warp_id), 64'd0);
    chk("rst_wb_dst_reg", 64'(bus.wb_dst_reg), 64'd0);
    chk("rst_sb_release", 64'(bus.sb_release_valid), 64'd0);
    chk("rst_sb_warp_id", 64'(bus.sb_release_warp_id), 64'd0);
    chk("rst_err", 64'(bus.err_timeout), 64'd0);
  endtask

  initial begin
    logic [31:0] m;
    bus.issue_valid   = 1'b0;
    bus.issue_warp_id = '0;
    bus.issue_dst_reg = '0;
    bus.issue_mask    = '0;
    bus.core_done     = '0;
    bus.core_result   = '0;
    bus.wb_ready      = 1'b0;
    #12 chk_reset_vals();
    @(negedge clk) rst = 1'b0;

    // all lanes complete together
    clear_sched();
    for (int l = 0; l < N; l++) begin
      done_cyc[l] = 1;
      res1[l]     = 32'(l * 2);
    end
    do_warp(5'd3, 6'd7, 32'hFFFF_FFFF, 0);

    // out-of-order lanes, spurious lane 9, duplicate on lane 1
    clear_sched();
    done_cyc[3] = 1; done_cyc[1] = 2; done_cyc[0] = 3; done_cyc[2] = 4;
    done_cyc[9] = 2; dup_cyc[1] = 3;
    do_warp(5'd11, 6'd2, 32'h0000_000F, 0);

    // timeout with lane 1 never completing
    clear_sched();
    done_cyc[0] = 2;
    do_warp(5'd20, 6'd40, 32'h0000_0003, 0);

    // zero mask, then a 5-cycle stall with a competing issue
    clear_sched();
    do_warp(5'd6, 6'd1, 32'h0, 0);
    clear_sched();
    done_cyc[4] = 1;
    do_warp(5'd9, 6'd9, 32'h0000_0010, 5);

    // reset during collection with two lanes pending
    @(negedge clk);
    bus.issue_valid   = 1'b1;
    bus.issue_warp_id = 5'd17;
    bus.issue_dst_reg = 6'd33;
    bus.issue_mask    = 32'h0000_0300;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.wb_ready    = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    bus.core_done = 32'h0000_0300;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    bus.core_done = '0;
    #1 chk_reset_vals();
    @(negedge clk);
    #1 chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    bus.wb_ready = 1'b0;

    // randomized warps
    for (int t = 0; t < 40; t++) begin
      clear_sched();
      case ($urandom_range(0, 4))
        0: m = '0;
        1: m = 32'hFFFF_FFFF;
        2: m = 32'(1) << $urandom_range(0, 31);
        default: m = $urandom;
      endcase
      for (int l = 0; l < N; l++) begin
        if ($urandom_range(0, 19) == 0) done_cyc[l] = 0;
        else if ($urandom_range(0, 29) == 0) done_cyc[l] = $urandom_range(TO + 1, TO + 4);
        else done_cyc[l] = $urandom_range(1, 6);
        dup_cyc[l] = done_cyc[l] + $urandom_range(0, 3);
        if (dup_cyc[l] == done_cyc[l]) dup_cyc[l] = 0;
      end
      do_warp(5'($urandom), 6'($urandom), m, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
